// File: rtl/regfile_write_checker_if.sv
// Tapped register-file write port plus the expected-entry push handshake
// feeding the write checker.
interface regfile_write_checker_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic            exp_valid;
   logic            exp_ready;
   logic [AW-1:0]   exp_addr;
   logic [XLEN-1:0] exp_data;
   logic            exp_last;

   modport master (
      output wr_en, wr_addr, wr_data,
      output exp_valid, exp_addr, exp_data, exp_last,
      input  exp_ready
   );

   modport slave (
      input  wr_en, wr_addr, wr_data,
      input  exp_valid, exp_addr, exp_data, exp_last,
      output exp_ready
   );
endinterface

// File: rtl/regfile_write_checker.sv
// Register-file write checker: compares every architectural write, in order,
// against a queue of expected (addr, data) pairs, keeps a shadow register
// file, and finishes on its own with PASS, FAIL or TIMEOUT.
module regfile_write_checker #(
   parameter int XLEN    = 32,
   parameter int NREGS   = 32,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 64,
   parameter int CW      = 16,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   regfile_write_checker_if.slave   bus,
   input  logic [AW-1:0]            shadow_raddr,
   output logic [XLEN-1:0]          shadow_rdata,
   output logic                     done,
   output logic                     pass,
   output logic                     fail,
   output logic                     timeout,
   output logic [CW-1:0]            checked_count,
   output logic [CW-1:0]            error_count,
   output logic [AW-1:0]            first_err_addr,
   output logic [XLEN-1:0]          first_err_data
);
   localparam int PW = $clog2(DEPTH);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   q_addr [DEPTH];
   logic [XLEN-1:0] q_data [DEPTH];
   logic            q_last [DEPTH];
   logic [PW:0]     wr_ptr, rd_ptr;
   logic [XLEN-1:0] shadow [NREGS];
   logic [WW-1:0]   wdog;

   logic          qual, empty, full, running, terminal;
   logic          push, pop, mismatch, unexpected, err;
   logic [PW-1:0] head;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + 1'b1;
   endfunction

   // Writes to x0 never count: they are invisible to compare, shadow and watchdog.
   assign qual       = bus.wr_en && (bus.wr_addr != '0);
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign head       = rd_ptr[PW-1:0];
   assign running    = (state == S_RUN);
   assign terminal   = (state == S_PASS) || (state == S_FAIL) || (state == S_TIMEOUT);
   // Readiness uses the current fill level, so a same-cycle pop cannot make room.
   assign push       = bus.exp_valid && !full && !terminal;
   assign pop        = running && qual && !empty;
   assign mismatch   = pop && ((q_addr[head] != bus.wr_addr) || (q_data[head] != bus.wr_data));
   assign unexpected = running && qual && empty;
   assign err        = mismatch || unexpected;

   assign bus.exp_ready = !full;
   assign shadow_rdata  = shadow[shadow_raddr];
   assign done          = terminal;
   assign pass          = (state == S_PASS);
   assign fail          = (state == S_FAIL);
   assign timeout       = (state == S_TIMEOUT);

   // Next-state decode: start launches a run, writes or the watchdog end it.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (qual) begin
               if (empty) begin
                  state_nxt = S_FAIL;
               end else if (q_last[head]) begin
                  state_nxt = ((error_count == '0) && !mismatch) ? S_PASS : S_FAIL;
               end
            end else if (wdog == WD_LAST) begin
               state_nxt = S_TIMEOUT;
            end
         end
         default: state_nxt = state;
      endcase
   end

   // State register; terminal states hold until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Queue pointers, watchdog, saturating counters and first-error capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         wdog           <= '0;
         checked_count  <= '0;
         error_count    <= '0;
         first_err_addr <= '0;
         first_err_data <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if ((state == S_IDLE) && start) begin
            wdog <= '0;
         end else if (running) begin
            wdog <= qual ? '0 : wdog + 1'b1;
         end
         if (pop) checked_count <= sat_inc(checked_count);
         if (err) begin
            error_count <= sat_inc(error_count);
            if (error_count == '0) begin
               first_err_addr <= bus.wr_addr;
               first_err_data <= bus.wr_data;
            end
         end
      end
   end

   // Expected-entry storage; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wr_ptr[PW-1:0]] <= bus.exp_addr;
         q_data[wr_ptr[PW-1:0]] <= bus.exp_data;
         q_last[wr_ptr[PW-1:0]] <= bus.exp_last;
      end
   end

   // Shadow register file follows every qualifying write in every state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) shadow[i] <= '0;
      end else if (qual) begin
         shadow[bus.wr_addr] <= bus.wr_data;
      end
   end
endmodule

// File: tb/tb_regfile_write_checker.sv
// Bench for regfile_write_checker: directed scenarios with literal
// expectations plus randomized runs against a queue-based reference model.
module tb_regfile_write_checker;
   localparam int XLEN    = 32;
   localparam int NREGS   = 32;
   localparam int AW      = 5;
   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 8;
   localparam int CW      = 4;

   localparam int P_IDLE = 0, P_RUN = 1, P_PASS = 2, P_FAIL = 3, P_TOUT = 4;

   typedef struct packed {
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      logic            l;
   } ent_t;

   logic            clk, reset, start;
   logic [AW-1:0]   shadow_raddr;
   logic [XLEN-1:0] shadow_rdata;
   logic            done, pass, fail, timeout;
   logic [CW-1:0]   checked_count, error_count;
   logic [AW-1:0]   first_err_addr;
   logic [XLEN-1:0] first_err_data;

   regfile_write_checker_if #(.XLEN(XLEN), .AW(AW)) bus ();

   regfile_write_checker #(
      .XLEN(XLEN), .NREGS(NREGS), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CW(CW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus),
      .shadow_raddr(shadow_raddr), .shadow_rdata(shadow_rdata),
      .done(done), .pass(pass), .fail(fail), .timeout(timeout),
      .checked_count(checked_count), .error_count(error_count),
      .first_err_addr(first_err_addr), .first_err_data(first_err_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model
   ent_t            mq[$];
   logic [XLEN-1:0] m_shadow [NREGS];
   int              m_phase, m_quiet, m_chk, m_err;
   logic [AW-1:0]   m_fa;
   logic [XLEN-1:0] m_fd;
   bit              m_pushed;

   function automatic int sat(input int v);
      return (v >= (1 << CW) - 1) ? v : v + 1;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      for (int i = 0; i < NREGS; i++) m_shadow[i] = '0;
      m_phase = P_IDLE; m_quiet = 0; m_chk = 0; m_err = 0;
      m_fa = '0; m_fd = '0; m_pushed = 0;
   endtask

   task automatic note_error();
      if (m_err == 0) begin
         m_fa = bus.wr_addr;
         m_fd = bus.wr_data;
      end
      m_err = sat(m_err);
   endtask

   // advance the model by one clock edge using the inputs present before it
   task automatic model_step();
      bit   qual, can_push;
      ent_t e;
      ent_t nw;
      if (reset) begin
         model_reset();
         return;
      end
      qual     = bus.wr_en && (bus.wr_addr != 0);
      can_push = bus.exp_valid && (mq.size() < DEPTH) && (m_phase <= P_RUN);
      nw       = '{a: bus.exp_addr, d: bus.exp_data, l: bus.exp_last};
      m_pushed = can_push;
      if (m_phase == P_IDLE) begin
         if (start) begin
            m_phase = P_RUN;
            m_quiet = 0;
         end
      end else if (m_phase == P_RUN) begin
         if (qual) begin
            m_quiet = 0;
            if (mq.size() == 0) begin
               note_error();
               m_phase = P_FAIL;
            end else begin
               e = mq.pop_front();
               m_chk = sat(m_chk);
               if (e.a != bus.wr_addr || e.d != bus.wr_data) note_error();
               if (e.l) m_phase = (m_err == 0) ? P_PASS : P_FAIL;
            end
         end else begin
            m_quiet++;
            if (m_quiet == TIMEOUT) m_phase = P_TOUT;
         end
      end
      if (can_push) mq.push_back(nw);
      if (qual) m_shadow[bus.wr_addr] = bus.wr_data;
   endtask

   task automatic check_all();
      check("exp_ready", bus.exp_ready, (mq.size() < DEPTH));
      check("done", done, (m_phase >= P_PASS));
      check("pass", pass, (m_phase == P_PASS));
      check("fail", fail, (m_phase == P_FAIL));
      check("timeout", timeout, (m_phase == P_TOUT));
      check("checked_count", checked_count, m_chk);
      check("error_count", error_count, m_err);
      check("first_err_addr", first_err_addr, m_fa);
      check("first_err_data", first_err_data, m_fd);
      check("shadow_rdata", shadow_rdata, m_shadow[shadow_raddr]);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      start = 0;
      bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.exp_valid = 0; bus.exp_addr = '0; bus.exp_data = '0; bus.exp_last = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      model_reset();
      #1;
      check_all();
      cycle();
      reset = 0;
   endtask

   task automatic push(input int a, input int d, input bit l);
      bus.exp_valid = 1; bus.exp_addr = AW'(a); bus.exp_data = XLEN'(d); bus.exp_last = l;
      cycle();
      bus.exp_valid = 0;
   endtask

   task automatic wr(input int a, input int d);
      bus.wr_en = 1; bus.wr_addr = AW'(a); bus.wr_data = XLEN'(d);
      cycle();
      bus.wr_en = 0;
   endtask

   task automatic pulse_start();
      start = 1;
      cycle();
      start = 0;
   endtask

   task automatic run_random();
      ent_t lst[$];
      int L, pre, pi, wi, r, c;
      do_reset();
      L = $urandom_range(1, 24);
      for (int i = 0; i < L; i++)
         lst.push_back('{a: AW'($urandom_range(1, NREGS - 1)), d: XLEN'($urandom), l: (i == L - 1)});
      pre = $urandom_range(0, (L < DEPTH) ? L : DEPTH);
      pi = 0;
      while (pi < pre) begin
         bus.exp_valid = 1; bus.exp_addr = lst[pi].a; bus.exp_data = lst[pi].d; bus.exp_last = lst[pi].l;
         cycle();
         if (m_pushed) pi++;
      end
      bus.exp_valid = 0;
      pulse_start();
      wi = 0;
      c = 0;
      while (m_phase == P_RUN && c < 150) begin
         bus.exp_valid = (pi < L) && ($urandom_range(0, 3) != 0);
         if (pi < L) begin
            bus.exp_addr = lst[pi].a; bus.exp_data = lst[pi].d; bus.exp_last = lst[pi].l;
         end
         bus.wr_en = 0;
         r = $urandom_range(0, 99);
         if (wi < L && r < 60) begin
            bus.wr_en = 1; bus.wr_addr = lst[wi].a; bus.wr_data = lst[wi].d;
            if (r < 4) bus.wr_data = lst[wi].d ^ 32'h1;
            if (r >= 4 && r < 8) bus.wr_addr = '0;
            else wi++;
         end
         start = ($urandom_range(0, 19) == 0);
         shadow_raddr = AW'($urandom_range(0, NREGS - 1));
         cycle();
         if (m_pushed) pi++;
         c++;
      end
      check("run ended", (m_phase != P_RUN), 1);
      for (int k = 0; k < 4; k++) begin
         bus.wr_en = 1; bus.wr_addr = AW'($urandom_range(0, NREGS - 1)); bus.wr_data = XLEN'($urandom);
         bus.exp_valid = 1;
         start = 1;
         shadow_raddr = bus.wr_addr;
         cycle();
      end
      idle_inputs();
   endtask

   initial begin
      reset = 0;
      shadow_raddr = '0;
      idle_inputs();

      // directed: three matching writes end in PASS
      do_reset();
      push(1, 5, 0); push(2, 10, 0); push(3, 15, 1);
      pulse_start();
      wr(1, 5); wr(2, 10);
      check("t1 pass early", pass, 0);
      wr(3, 15);
      check("t1 pass", pass, 1);
      check("t1 checked", checked_count, 3);
      check("t1 errors", error_count, 0);
      shadow_raddr = 3; #1;
      check("t1 shadow x3", shadow_rdata, 15);

      // directed: data mismatch on the last entry
      do_reset();
      push(1, 5, 0); push(2, 10, 1);
      pulse_start();
      wr(1, 5); wr(2, 11);
      check("t2 fail", fail, 1);
      check("t2 errors", error_count, 1);
      check("t2 err addr", first_err_addr, 2);
      check("t2 err data", first_err_data, 11);

      // directed: x0 write ignored
      do_reset();
      push(4, 7, 1);
      pulse_start();
      wr(0, 99);
      check("t3 no pop on x0", checked_count, 0);
      wr(4, 7);
      check("t3 pass", pass, 1);
      check("t3 checked", checked_count, 1);
      shadow_raddr = 0; #1;
      check("t3 shadow x0", shadow_rdata, 0);

      // directed: write against an empty queue, with a same-cycle push
      do_reset();
      pulse_start();
      bus.exp_valid = 1; bus.exp_addr = 5; bus.exp_data = 3; bus.exp_last = 1;
      wr(5, 3);
      bus.exp_valid = 0;
      check("t4 fail", fail, 1);
      check("t4 err addr", first_err_addr, 5);
      shadow_raddr = 5; #1;
      check("t4 shadow x5", shadow_rdata, 3);

      // directed: watchdog expires exactly TIMEOUT cycles after start
      do_reset();
      push(1, 1, 1);
      pulse_start();
      for (int i = 0; i < TIMEOUT - 1; i++) cycle();
      check("t5 timeout early", timeout, 0);
      cycle();
      check("t5 timeout", timeout, 1);
      check("t5 pass", pass, 0);
      check("t5 fail", fail, 0);

      // directed: full queue, refused push on same-cycle pop, reset mid-run
      do_reset();
      for (int i = 0; i < DEPTH; i++) push((i % 31) + 1, i * 3, 0);
      check("t6 full ready", bus.exp_ready, 0);
      push(9, 9, 0);
      pulse_start();
      bus.exp_valid = 1; bus.exp_addr = 30; bus.exp_data = 30; bus.exp_last = 1;
      wr(1, 0);
      bus.exp_valid = 0;
      check("t6 refused push", bus.exp_ready, 1);
      check("t6 checked", checked_count, 1);
      reset = 1;
      model_reset();
      #1;
      check("t6 rst done", done, 0);
      check("t6 rst checked", checked_count, 0);
      check("t6 rst ready", bus.exp_ready, 1);
      check_all();
      cycle();
      reset = 0;
      wr(2, 3);
      check("t6 idle after rst", checked_count, 0);

      // directed: checked_count saturates
      do_reset();
      for (int i = 0; i < DEPTH; i++) push(i + 1, i + 100, (i == DEPTH - 1));
      pulse_start();
      for (int i = 0; i < DEPTH; i++) wr(i + 1, i + 100);
      check("t7 pass", pass, 1);
      check("t7 checked sat", checked_count, (1 << CW) - 1);

      // randomized runs
      for (int s = 0; s < 30; s++) run_random();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/regfile_write_checker.md
Name: regfile_write_checker

Overview:
Self-checking monitor that replaces the fixed-delay, print-only register watch used in processor benches. It taps the register-file write port and compares every architectural write, in order, against a preloaded queue of expected (address, data) pairs. It also keeps a shadow copy of all NREGS registers and ends the run on its own with PASS, FAIL or TIMEOUT.

Parameters:
XLEN, 32, data width of register writes
NREGS, 32, number of architectural registers; AW = $clog2(NREGS)
DEPTH, 16, expected-write queue depth (power of 2)
TIMEOUT, 64, cycles without an observed write before a RUN is aborted
CW, 16, width of the saturating counters

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  one-cycle pulse; IDLE->RUN
wr_en  in  1  register-file write enable (tapped)
wr_addr  in  AW  register-file write address
wr_data  in  XLEN  register-file write data
exp_valid  in  1  expected entry offered
exp_ready  out  1  queue can accept an entry
exp_addr  in  AW  expected destination register
exp_data  in  XLEN  expected value
exp_last  in  1  marks the final expected entry
shadow_raddr  in  AW  shadow read address
shadow_rdata  out  XLEN  shadow register value, combinational read
done  out  1  run finished (PASS/FAIL/TIMEOUT)
pass  out  1  finished with no error
fail  out  1  mismatch or unexpected write
timeout  out  1  watchdog expired
checked_count  out  CW  compared writes, saturating
error_count  out  CW  mismatches plus unexpected writes, saturating
first_err_addr  out  AW  wr_addr of the first error
first_err_data  out  XLEN  wr_data of the first error

Behaviour:
- Reset (async assert, sync release): state IDLE, queue empty, shadow all 0, counters 0, done/pass/fail/timeout 0, first_err_* 0, exp_ready 1.
- Queue: FIFO of {addr, data, last}. Push when exp_valid && exp_ready. exp_ready = !full. Pushes are allowed in IDLE and RUN, and are dropped in terminal states.
- Writes with wr_addr == 0 are ignored entirely: no compare, no pop, no shadow update, no watchdog reset. Shadow[0] stays 0.
- Shadow: any wr_en with wr_addr != 0 updates shadow[wr_addr] next edge, in every state.
- States:
  - IDLE: observed writes update the shadow only. start moves to RUN and clears the watchdog.
  - RUN: on a qualifying write:
    - Queue non-empty: pop the head, compare, checked_count++. On mismatch, error_count++ and capture first_err_* if this is the first error. If the head has last set, go to PASS when error_count (including this write) is 0, otherwise go to FAIL.
    - Queue empty: unexpected write; error_count++, capture first_err_*, and go to FAIL.
  - Watchdog: counts every RUN cycle without a qualifying write. At TIMEOUT it goes to TIMEOUT (timeout=1).
- Terminal states PASS, FAIL and TIMEOUT are sticky until reset. done=1, plus pass, fail or timeout respectively, registered in the same cycle the state is entered. Compares stop; the shadow keeps updating.
- Simultaneous push and pop on a full queue: the pop frees a slot, but exp_ready is computed from current full, so the push is refused that cycle. On an empty queue, an entry pushed this cycle is not visible to a same-cycle write, so that write counts as unexpected.
- Counters saturate at 2^CW-1.
- start outside IDLE is ignored. Reset mid-RUN aborts immediately to IDLE.

Test Plan:
- Load (1,5),(2,10),(3,15,last); start; writes x1=5, x2=10, x3=15 -> pass=1 the cycle after the x3 write, checked_count=3, error_count=0, shadow_rdata[3]=15.
- Load (1,5),(2,10,last); writes x1=5, x2=11 -> fail=1, error_count=1, first_err_addr=2, first_err_data=11.
- Load (4,7,last); write x0=99, then x4=7 -> x0 ignored, shadow[0]=0, pass=1, checked_count=1.
- Start with empty queue; write x5=3 -> fail=1, first_err_addr=5; shadow[5]=3.
- TIMEOUT=8; load one entry; start; no writes -> timeout=1 exactly 8 cycles after start; pass and fail stay 0.
- Fill 16 entries -> exp_ready=0. Pop and push in the same cycle -> push refused. Assert reset mid-RUN -> all outputs 0 and state IDLE with no clock edge.
